// File: rtl/bwt_pkg.sv
// Shared types and default sizes for the BWT emitter slice.
package bwt_pkg;
  localparam int STRING_LEN_DEF = 8;
  localparam int CHAR_W_DEF     = 8;
  localparam int IDX_W_DEF      = 8;

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, DONE = 2'd2} state_e;

  typedef logic [CHAR_W_DEF-1:0]    char_t;
  typedef logic [IDX_W_DEF-1:0]     idx_t;
  typedef char_t [STRING_LEN_DEF-1:0] str_t;
  typedef idx_t  [STRING_LEN_DEF-1:0] sa_t;
endpackage

// File: rtl/bwt_perm_checker.sv
// Tracks which suffix indices were emitted; flags duplicates, out-of-range
// entries and missing indices by the last transfer.
module bwt_perm_checker
  import bwt_pkg::*;
#(
  parameter int STRING_LEN = STRING_LEN_DEF,
  parameter int IDX_W      = IDX_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             xfer,
  input  logic             fin,
  input  logic [IDX_W-1:0] sa_val,
  output logic             perm_err
);
  logic [STRING_LEN-1:0] seen, hit;
  logic                  dup, oor, missing;

  always_comb begin
    hit = '0;
    for (int i = 0; i < STRING_LEN; i++) hit[i] = (sa_val == IDX_W'(i));
  end

  assign dup     = |(hit & seen);
  assign oor     = ~|hit;
  // Include the current transfer so the flag is already visible during DONE.
  assign missing = fin && ~&(seen | hit);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      seen     <= '0;
      perm_err <= 1'b0;
    end else if (xfer) begin
      seen <= seen | hit;
      if (dup || oor || missing) perm_err <= 1'b1;
    end
  end
endmodule

// File: rtl/bwt_emitter.sv
// Streams bwt[i] = str[(sa[i]-1) mod STRING_LEN] with a valid/ready handshake.
// Optional permutation checking is enabled by defining BWT_PERM_CHECK_EN.
module bwt_emitter
  import bwt_pkg::*;
#(
  parameter int STRING_LEN = STRING_LEN_DEF,
  parameter int CHAR_W     = CHAR_W_DEF,
  parameter int IDX_W      = IDX_W_DEF
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [STRING_LEN-1:0][CHAR_W-1:0] input_string,
  input  logic [STRING_LEN-1:0][IDX_W-1:0]  suffixes_in,
  output logic [CHAR_W-1:0]                 out_char,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic [IDX_W-1:0]                  primary_idx,
  output logic                              done,
  output logic                              busy,
  output logic                              range_err,
  output logic                              prim_err
`ifdef BWT_PERM_CHECK_EN
  ,
  output logic                              perm_err
`endif
);
  localparam logic [1:0]       ST_IDLE = IDLE;
  localparam logic [1:0]       ST_EMIT = EMIT;
  localparam logic [1:0]       ST_DONE = DONE;
  localparam logic [IDX_W:0]   LEN     = (IDX_W+1)'(STRING_LEN);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(STRING_LEN-1);

  logic [1:0]                        state;
  logic [IDX_W-1:0]                  idx, cur_sa, src;
  logic [STRING_LEN-1:0][CHAR_W-1:0] str_q;
  logic [STRING_LEN-1:0][IDX_W-1:0]  sa_q;
  logic                              found_zero, in_range, sa_zero, xfer;

  // Explicit muxes keep index widths independent of IDX_W vs log2(STRING_LEN).
  always_comb begin
    cur_sa = '0;
    for (int i = 0; i < STRING_LEN; i++)
      if (idx == IDX_W'(i)) cur_sa = sa_q[i];
  end

  assign in_range = {1'b0, cur_sa} < LEN;
  assign sa_zero  = (cur_sa == '0);
  assign src      = sa_zero ? LAST : cur_sa - 1'b1;

  always_comb begin
    out_char = '0;
    if (in_range)
      for (int i = 0; i < STRING_LEN; i++)
        if (src == IDX_W'(i)) out_char = str_q[i];
  end

  assign out_valid = (state == ST_EMIT);
  assign out_last  = out_valid && (idx == LAST);
  assign xfer      = out_valid && out_ready;
  assign done      = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      str_q       <= '0;
      sa_q        <= '0;
      primary_idx <= '0;
      found_zero  <= 1'b0;
      range_err   <= 1'b0;
      prim_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          str_q       <= input_string;
          sa_q        <= suffixes_in;
          idx         <= '0;
          primary_idx <= '0;
          found_zero  <= 1'b0;
          range_err   <= 1'b0;
          prim_err    <= 1'b0;
          state       <= ST_EMIT;
        end
        ST_EMIT: if (xfer) begin
          if (sa_zero && !found_zero) begin
            primary_idx <= idx;
            found_zero  <= 1'b1;
          end
          if (!in_range) range_err <= 1'b1;
          if (out_last) begin
            // Resolve prim_err now so it is valid alongside the done pulse.
            prim_err <= !(found_zero || sa_zero);
            state    <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BWT_PERM_CHECK_EN
  bwt_perm_checker #(.STRING_LEN(STRING_LEN), .IDX_W(IDX_W)) u_perm (
    .clk      (clk),
    .rst      (rst),
    .clr      ((state == ST_IDLE) && start),
    .xfer     (xfer),
    .fin      (xfer && out_last),
    .sa_val   (cur_sa),
    .perm_err (perm_err)
  );
`endif
endmodule

// File: tb/tb_bwt_emitter.sv
// Table-driven bench with an expected-character scoreboard for bwt_emitter.
module tb_bwt_emitter;
  localparam int N = 8;

  typedef struct {
    logic [7:0] str[N];
    int         sa[N];
    logic [7:0] exp[N];
    bit         bp;
    int         prim;
    bit         rerr;
    bit         perr;
    bit         pmerr;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, out_ready;
  logic [N-1:0][7:0] input_string, suffixes_in;
  logic [7:0] out_char, primary_idx;
  logic out_valid, out_last, done, busy, range_err, prim_err;
`ifdef BWT_PERM_CHECK_EN
  logic perm_err;
`endif

  always #5 clk = ~clk;

  bwt_emitter #(.STRING_LEN(N), .CHAR_W(8), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .input_string(input_string), .suffixes_in(suffixes_in),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .primary_idx(primary_idx), .done(done),
    .busy(busy), .range_err(range_err), .prim_err(prim_err)
`ifdef BWT_PERM_CHECK_EN
    , .perm_err(perm_err)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < N; i++) begin
      input_string[i] = v.str[i];
      suffixes_in[i]  = 8'(v.sa[i]);
    end
  endtask

  // mid_start >= 0 pulses start (with garbage inputs) at that cycle of the stream.
  task automatic run(input vec_t v, input int mid_start);
    bit got_done;
    load(v);
    exp_q.delete();
    for (int i = 0; i < N; i++) exp_q.push_back(v.exp[i]);
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got_done = 1'b0;
    for (int cyc = 0; cyc < 64 && !got_done; cyc++) begin
      out_ready = v.bp ? (cyc % 3 == 0) : 1'b1;
      if (cyc == mid_start) begin
        start = 1'b1;
        input_string = '0;
        suffixes_in  = '0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        chk("done_after_last", exp_q.size(), 0);
        if (!v.bp) chk("done_latency", cyc, N);
        chk("done_out_valid", out_valid, 0);
        chk("done_busy", busy, 1);
        chk("primary_idx", primary_idx, v.prim);
        chk("range_err", range_err, v.rerr);
        chk("prim_err", prim_err, v.perr);
`ifdef BWT_PERM_CHECK_EN
        chk("perm_err", perm_err, v.pmerr);
`endif
      end else if (!out_valid) begin
        chk("out_valid_gap", out_valid, 1);
      end else if (exp_q.size() == 0) begin
        chk("stream_len", exp_q.size(), 1);
      end else begin
        chk(out_ready ? "out_char" : "out_char_hold", out_char, exp_q[0]);
        chk("out_last", out_last, exp_q.size() == 1);
        if (out_ready) void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    if (!got_done) chk("done_timeout", got_done, 1);
    @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_range_err_hold", range_err, v.rerr);
    chk("idle_prim_idx_hold", primary_idx, v.prim);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done;
    vecs[0].str = '{"b", "a", "n", "a", "n", "a", "s", "$"};
    vecs[0].sa  = '{7, 1, 3, 5, 0, 2, 4, 6};
    vecs[0].exp = '{"s", "b", "n", "n", "$", "a", "a", "a"};
    vecs[0].bp = 0; vecs[0].prim = 4; vecs[0].rerr = 0; vecs[0].perr = 0; vecs[0].pmerr = 0;
    vecs[1].str = '{"a", "b", "c", "d", "e", "f", "g", "h"};
    vecs[1].sa  = '{0, 1, 2, 3, 4, 5, 6, 7};
    vecs[1].exp = '{"h", "a", "b", "c", "d", "e", "f", "g"};
    vecs[1].bp = 0; vecs[1].prim = 0; vecs[1].rerr = 0; vecs[1].perr = 0; vecs[1].pmerr = 0;
    vecs[2] = vecs[0];
    vecs[2].bp = 1;
    vecs[3].str = vecs[0].str;
    vecs[3].sa  = '{1, 1, 2, 3, 4, 5, 6, 9};
    vecs[3].exp = '{"b", "b", "a", "n", "a", "n", "a", 8'h00};
    vecs[3].bp = 0; vecs[3].prim = 0; vecs[3].rerr = 1; vecs[3].perr = 1; vecs[3].pmerr = 1;

    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    input_string = '0; suffixes_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_prim_err", prim_err, 0);
    chk("rst_out_char", out_char, 0);
    chk("rst_primary_idx", primary_idx, 0);
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) run(vecs[k], -1);

    // start while streaming must be ignored
    run(vecs[0], 2);

    // reset after three transfers
    load(vecs[0]);
    out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_primary_idx", primary_idx, 0);
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || out_valid) seen_done++;
    end
    chk("midrst_no_partial_done", seen_done, 0);

    // back to normal operation after the reset
    run(vecs[1], -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
